// File: rtl/axil_ram_responder_if.sv
// AXI4-Lite channel bundle between the DMA initiator and the packet-buffer RAM responder.
interface axil_ram_responder_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_ram_responder.sv
// AXI4-Lite slave over a single-port word RAM; reads and writes share the port via a fair arbiter.
// Latency: write accepted in N gives bvalid in N+1; read accepted in N gives rvalid/rdata in N+1.
// Backpressure: a held B (R) response blocks new write (read) acceptance until bready (rready).
module axil_ram_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    axil_ram_responder_if.slave  s_axil
);
    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

    logic [31:0] mem [DEPTH];

    grant_e      last_grant;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;

    logic                  wr_elig, rd_elig;
    logic                  wr_go, rd_go;
    logic                  wr_hit, rd_hit;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;

    // BASE_ADDR is aligned to the RAM size, so range check reduces to comparing the upper bits.
    assign wr_hit = (s_axil.awaddr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign rd_hit = (s_axil.araddr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign wr_idx = s_axil.awaddr[ADDR_WIDTH+1:2];
    assign rd_idx = s_axil.araddr[ADDR_WIDTH+1:2];

    assign wr_elig = s_axil.awvalid && s_axil.wvalid && (!bvalid_q || s_axil.bready);
    assign rd_elig = s_axil.arvalid && (!rvalid_q || s_axil.rready);

    always_comb begin
        wr_go = 1'b0;
        rd_go = 1'b0;
        if (!i_rst) begin
            if (wr_elig && rd_elig) begin
                wr_go = (last_grant == GRANT_READ);
                rd_go = (last_grant == GRANT_WRITE);
            end else begin
                wr_go = wr_elig;
                rd_go = rd_elig;
            end
        end
    end

    assign s_axil.awready = wr_go;
    assign s_axil.wready  = wr_go;
    assign s_axil.arready = rd_go;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

    always_ff @(posedge i_clk) begin
        if (wr_go && wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axil.wstrb[b]) begin
                    mem[wr_idx][8*b +: 8] <= s_axil.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rdata_q    <= 32'h0;
            last_grant <= GRANT_READ;
        end else begin
            if (wr_go) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_hit ? OKAY : DECERR;
            end else if (s_axil.bready) begin
                bvalid_q <= 1'b0;
            end

            if (rd_go) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_hit ? OKAY : DECERR;
                rdata_q  <= rd_hit ? mem[rd_idx] : 32'h0;
            end else if (s_axil.rready) begin
                rvalid_q <= 1'b0;
            end

            if (wr_elig && rd_elig) begin
                last_grant <= wr_go ? GRANT_WRITE : GRANT_READ;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[1:0], s_axil.araddr[1:0]};
endmodule

// File: tb/tb_axil_ram_responder.sv
// Directed vector table plus hand sequences for conflict, backpressure and reset corners.
module tb_axil_ram_responder;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    axil_ram_responder_if bus();

    axil_ram_responder #(.ADDR_WIDTH(12), .BASE_ADDR(BASE)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .s_axil (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        logic [3:0]  strb;
        logic [1:0]  resp;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic got);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (bus.awready && bus.wready) got = 1'b1;
            else begin @(posedge i_clk); #1; end
        end
        @(posedge i_clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        got  = got && bus.bvalid;
        resp = bus.bresp;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output logic got);
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (bus.arready) got = 1'b1;
            else begin @(posedge i_clk); #1; end
        end
        @(posedge i_clk); #1;
        bus.arvalid = 1'b0;
        got  = got && bus.rvalid;
        resp = bus.rresp;
        d    = bus.rdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        ok;

        vt[0]  = '{1'b1, BASE + 32'h10,   32'hDEAD_BEEF, 4'hF, 2'b00};
        vt[1]  = '{1'b0, BASE + 32'h10,   32'hDEAD_BEEF, 4'h0, 2'b00};
        vt[2]  = '{1'b1, BASE + 32'h20,   32'h1122_3344, 4'hF, 2'b00};
        vt[3]  = '{1'b1, BASE + 32'h20,   32'hAABB_CCDD, 4'b0101, 2'b00};
        vt[4]  = '{1'b0, BASE + 32'h20,   32'h11BB_33DD, 4'h0, 2'b00};
        vt[5]  = '{1'b1, BASE + 32'h0,    32'hCAFE_F00D, 4'hF, 2'b00};
        vt[6]  = '{1'b1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF, 2'b11};
        vt[7]  = '{1'b0, BASE + 32'h4000, 32'h0000_0000, 4'h0, 2'b11};
        vt[8]  = '{1'b0, BASE + 32'h0,    32'hCAFE_F00D, 4'h0, 2'b00};
        vt[9]  = '{1'b1, BASE - 32'h4,    32'h1234_5678, 4'hF, 2'b11};
        vt[10] = '{1'b0, BASE + 32'h0,    32'hCAFE_F00D, 4'h0, 2'b00};
        vt[11] = '{1'b1, BASE + 32'h20,   32'h9999_9999, 4'h0, 2'b00};
        vt[12] = '{1'b0, BASE + 32'h22,   32'h11BB_33DD, 4'h0, 2'b00};
        vt[13] = '{1'b1, BASE + 32'h3FFC, 32'h0BAD_C0DE, 4'hF, 2'b00};
        vt[14] = '{1'b0, BASE + 32'h3FFF, 32'h0BAD_C0DE, 4'h0, 2'b00};

        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        bus.awaddr = BASE; bus.araddr = BASE; bus.wdata = 32'h0; bus.wstrb = 4'hF;
        bus.awprot = 3'b0; bus.arprot = 3'b0; bus.bready = 1'b1; bus.rready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst awready", bus.awready, 0);
        chk("rst wready",  bus.wready,  0);
        chk("rst arready", bus.arready, 0);
        chk("rst bvalid",  bus.bvalid,  0);
        chk("rst rvalid",  bus.rvalid,  0);
        chk("rst bresp",   bus.bresp,   0);
        chk("rst rresp",   bus.rresp,   0);
        chk("rst rdata",   bus.rdata,   0);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        i_rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (vt[i].is_wr) begin
                axi_write(vt[i].addr, vt[i].data, vt[i].strb, rs, ok);
                chk($sformatf("v%0d bvalid", i), ok, 1);
                chk($sformatf("v%0d bresp", i), rs, vt[i].resp);
            end else begin
                axi_read(vt[i].addr, rd, rs, ok);
                chk($sformatf("v%0d rvalid", i), ok, 1);
                chk($sformatf("v%0d rresp", i), rs, vt[i].resp);
                chk($sformatf("v%0d rdata", i), rd, vt[i].data);
            end
        end

        // Conflict: both channels eligible every cycle, grants must alternate starting with write.
        axi_write(BASE + 32'h30, 32'h0, 4'hF, rs, ok);
        bus.awaddr = BASE + 32'h30; bus.araddr = BASE + 32'h30;
        bus.wdata = 32'h5; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("conf%0d awready", i), bus.awready, (i % 2 == 0));
            chk($sformatf("conf%0d arready", i), bus.arready, (i % 2 == 1));
            if (i == 2) begin
                chk("conf rvalid", bus.rvalid, 1);
                chk("conf rdata", bus.rdata, 32'h5);
            end
            @(posedge i_clk); #1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;

        // Write response backpressure.
        bus.bready = 1'b0;
        bus.awaddr = BASE + 32'h40; bus.wdata = 32'h0102_0304; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        #1;
        chk("bp_w first awready", bus.awready, 1);
        @(posedge i_clk); #1;
        bus.awaddr = 32'h0002_0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_w%0d awready", i), bus.awready, 0);
            chk($sformatf("bp_w%0d bvalid", i), bus.bvalid, 1);
            chk($sformatf("bp_w%0d bresp", i), bus.bresp, 2'b00);
            @(posedge i_clk); #1;
        end
        bus.bready = 1'b1;
        #1;
        chk("bp_w release awready", bus.awready, 1);
        @(posedge i_clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("bp_w second bvalid", bus.bvalid, 1);
        chk("bp_w second bresp", bus.bresp, 2'b11);
        @(posedge i_clk); #1;
        chk("bp_w drain bvalid", bus.bvalid, 0);

        // Read response backpressure.
        axi_write(BASE + 32'h44, 32'h5A5A_1234, 4'hF, rs, ok);
        bus.rready = 1'b0;
        bus.araddr = BASE + 32'h44; bus.arvalid = 1'b1;
        #1;
        chk("bp_r first arready", bus.arready, 1);
        @(posedge i_clk); #1;
        bus.araddr = BASE + 32'h40;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_r%0d arready", i), bus.arready, 0);
            chk($sformatf("bp_r%0d rvalid", i), bus.rvalid, 1);
            chk($sformatf("bp_r%0d rdata", i), bus.rdata, 32'h5A5A_1234);
            @(posedge i_clk); #1;
        end
        bus.rready = 1'b1;
        #1;
        chk("bp_r release arready", bus.arready, 1);
        @(posedge i_clk); #1;
        bus.arvalid = 1'b0;
        chk("bp_r second rvalid", bus.rvalid, 1);
        chk("bp_r second rdata", bus.rdata, 32'h0102_0304);
        @(posedge i_clk); #1;
        chk("bp_r drain rvalid", bus.rvalid, 0);

        // Reset while a read response is stalled and a write is offered in the reset cycle.
        axi_write(BASE + 32'h48, 32'h1357_9BDF, 4'hF, rs, ok);
        bus.rready = 1'b0;
        bus.araddr = BASE + 32'h44; bus.arvalid = 1'b1;
        @(posedge i_clk); #1;
        chk("mid_rst rvalid before", bus.rvalid, 1);
        i_rst = 1'b1;
        bus.awaddr = BASE + 32'h48; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        #1;
        chk("mid_rst awready", bus.awready, 0);
        @(posedge i_clk); #1;
        chk("mid_rst rvalid", bus.rvalid, 0);
        chk("mid_rst bvalid", bus.bvalid, 0);
        chk("mid_rst rdata", bus.rdata, 0);
        chk("mid_rst rresp", bus.rresp, 0);
        chk("mid_rst arready", bus.arready, 0);
        i_rst = 1'b0;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(posedge i_clk); #1;
        axi_read(BASE + 32'h48, rd, rs, ok);
        chk("post_rst rvalid", ok, 1);
        chk("post_rst rresp", rs, 2'b00);
        chk("post_rst rdata", rd, 32'h1357_9BDF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
